// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control pipeline with retired-instruction counter
module ctrl_pipe #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VALIDD,
  input  logic              WREGD,
  input  logic              REGRTD,
  input  logic              ALUIMMD,
  input  logic              BRANCHD,
  input  logic              EQNED,
  input  logic              WMEMD,
  input  logic              M2REGD,
  input  logic [1:0]        ALUOPD,
  input  logic [REG_AW-1:0] RTD,
  input  logic [REG_AW-1:0] RDD,
  input  logic              STALLD,
  input  logic              FLUSHE,
  output logic              WREGE,
  output logic              ALUIMME,
  output logic              BRANCHE,
  output logic              EQNEE,
  output logic              WMEME,
  output logic              M2REGE,
  output logic [1:0]        ALUOPE,
  output logic [REG_AW-1:0] WRITEREGE,
  output logic              WREGM,
  output logic              WMEMM,
  output logic              M2REGM,
  output logic [REG_AW-1:0] WRITEREGM,
  output logic              WREGW,
  output logic              M2REGW,
  output logic [REG_AW-1:0] WRITEREGW,
  output logic              VALIDE,
  output logic              VALIDM,
  output logic              VALIDW,
  output logic [CNT_W-1:0]  INSTRET
);

  // Stall, flush and an empty decode slot all collapse to the same bubble.
  logic take_d;
  assign take_d = VALIDD & ~STALLD & ~FLUSHE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VALIDE    <= 1'b0;
      WREGE     <= 1'b0;
      ALUIMME   <= 1'b0;
      BRANCHE   <= 1'b0;
      EQNEE     <= 1'b0;
      WMEME     <= 1'b0;
      M2REGE    <= 1'b0;
      ALUOPE    <= 2'b00;
      WRITEREGE <= '0;
      VALIDM    <= 1'b0;
      WREGM     <= 1'b0;
      WMEMM     <= 1'b0;
      M2REGM    <= 1'b0;
      WRITEREGM <= '0;
      VALIDW    <= 1'b0;
      WREGW     <= 1'b0;
      M2REGW    <= 1'b0;
      WRITEREGW <= '0;
      INSTRET   <= '0;
    end else begin
      if (take_d) begin
        VALIDE    <= 1'b1;
        WREGE     <= WREGD;
        ALUIMME   <= ALUIMMD;
        BRANCHE   <= BRANCHD;
        EQNEE     <= EQNED;
        WMEME     <= WMEMD;
        M2REGE    <= M2REGD;
        ALUOPE    <= ALUOPD;
        WRITEREGE <= REGRTD ? RDD : RTD;
      end else begin
        VALIDE    <= 1'b0;
        WREGE     <= 1'b0;
        ALUIMME   <= 1'b0;
        BRANCHE   <= 1'b0;
        EQNEE     <= 1'b0;
        WMEME     <= 1'b0;
        M2REGE    <= 1'b0;
        ALUOPE    <= 2'b00;
        WRITEREGE <= '0;
      end

      VALIDM    <= VALIDE;
      WREGM     <= WREGE;
      WMEMM     <= WMEME;
      M2REGM    <= M2REGE;
      WRITEREGM <= WRITEREGE;

      VALIDW    <= VALIDM;
      WREGW     <= WREGM;
      M2REGW    <= M2REGM;
      WRITEREGW <= WRITEREGM;

      // Counts the entry leaving WB on this edge; wraps silently.
      if (VALIDW) INSTRET <= INSTRET + 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - table-driven self-checking bench for ctrl_pipe
module tb_ctrl_pipe;

  logic       CLK, RST;
  logic       VALIDD, WREGD, REGRTD, ALUIMMD, BRANCHD, EQNED, WMEMD, M2REGD;
  logic [1:0] ALUOPD;
  logic [4:0] RTD, RDD;
  logic       STALLD, FLUSHE;
  logic       WREGE, ALUIMME, BRANCHE, EQNEE, WMEME, M2REGE;
  logic [1:0] ALUOPE;
  logic [4:0] WRITEREGE, WRITEREGM, WRITEREGW;
  logic       WREGM, WMEMM, M2REGM, WREGW, M2REGW;
  logic       VALIDE, VALIDM, VALIDW;
  logic [31:0] INSTRET;

  logic       d4_wrege, d4_aluimme, d4_branche, d4_eqnee, d4_wmeme, d4_m2rege;
  logic [1:0] d4_aluope;
  logic [4:0] d4_wre, d4_wrm, d4_wrw;
  logic       d4_wregm, d4_wmemm, d4_m2regm, d4_wregw, d4_m2regw;
  logic       d4_ve, d4_vm, d4_vw;
  logic [3:0] INSTRET4;

  ctrl_pipe #(.REG_AW(5), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .VALIDD(VALIDD), .WREGD(WREGD), .REGRTD(REGRTD),
    .ALUIMMD(ALUIMMD), .BRANCHD(BRANCHD), .EQNED(EQNED), .WMEMD(WMEMD),
    .M2REGD(M2REGD), .ALUOPD(ALUOPD), .RTD(RTD), .RDD(RDD), .STALLD(STALLD),
    .FLUSHE(FLUSHE), .WREGE(WREGE), .ALUIMME(ALUIMME), .BRANCHE(BRANCHE),
    .EQNEE(EQNEE), .WMEME(WMEME), .M2REGE(M2REGE), .ALUOPE(ALUOPE),
    .WRITEREGE(WRITEREGE), .WREGM(WREGM), .WMEMM(WMEMM), .M2REGM(M2REGM),
    .WRITEREGM(WRITEREGM), .WREGW(WREGW), .M2REGW(M2REGW), .WRITEREGW(WRITEREGW),
    .VALIDE(VALIDE), .VALIDM(VALIDM), .VALIDW(VALIDW), .INSTRET(INSTRET)
  );

  ctrl_pipe #(.REG_AW(5), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .VALIDD(VALIDD), .WREGD(WREGD), .REGRTD(REGRTD),
    .ALUIMMD(ALUIMMD), .BRANCHD(BRANCHD), .EQNED(EQNED), .WMEMD(WMEMD),
    .M2REGD(M2REGD), .ALUOPD(ALUOPD), .RTD(RTD), .RDD(RDD), .STALLD(STALLD),
    .FLUSHE(FLUSHE), .WREGE(d4_wrege), .ALUIMME(d4_aluimme), .BRANCHE(d4_branche),
    .EQNEE(d4_eqnee), .WMEME(d4_wmeme), .M2REGE(d4_m2rege), .ALUOPE(d4_aluope),
    .WRITEREGE(d4_wre), .WREGM(d4_wregm), .WMEMM(d4_wmemm), .M2REGM(d4_m2regm),
    .WRITEREGM(d4_wrm), .WREGW(d4_wregw), .M2REGW(d4_m2regw), .WRITEREGW(d4_wrw),
    .VALIDE(d4_ve), .VALIDM(d4_vm), .VALIDW(d4_vw), .INSTRET(INSTRET4)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       v, wr, rrt, ai, br, eq, wm, m2;
    logic [1:0] op;
    logic [4:0] rt, rd;
    logic       st, fl;
    logic       ev, ewr, eai, ebr, eeq, ewm, em2;
    logic [1:0] eop;
    logic [4:0] ewreg;
  } vec_t;

  typedef struct {
    logic       v, wr, wm, m2;
    logic [4:0] wreg;
  } stg_t;

  int   tests = 0;
  int   fails = 0;
  stg_t me, mm, mw;
  logic [31:0] cnt;
  logic [3:0]  cnt4;
  int   retired;
  vec_t tbl[14];
  vec_t vv;

  logic [30:0] all_out;
  assign all_out = {WREGE, ALUIMME, BRANCHE, EQNEE, WMEME, M2REGE, ALUOPE, WRITEREGE,
                    WREGM, WMEMM, M2REGM, WRITEREGM, WREGW, M2REGW, WRITEREGW,
                    VALIDE, VALIDM, VALIDW};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, wr, rrt, ai, br, eq, wm, m2,
                              input logic [1:0] op, input logic [4:0] rt, rd,
                              input logic st, fl,
                              input logic ev, ewr, eai, ebr, eeq, ewm, em2,
                              input logic [1:0] eop, input logic [4:0] ewreg);
    vec_t t;
    t.v = v; t.wr = wr; t.rrt = rrt; t.ai = ai; t.br = br; t.eq = eq; t.wm = wm; t.m2 = m2;
    t.op = op; t.rt = rt; t.rd = rd; t.st = st; t.fl = fl;
    t.ev = ev; t.ewr = ewr; t.eai = eai; t.ebr = ebr; t.eeq = eeq; t.ewm = ewm; t.em2 = em2;
    t.eop = eop; t.ewreg = ewreg;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    VALIDD = t.v; WREGD = t.wr; REGRTD = t.rrt; ALUIMMD = t.ai; BRANCHD = t.br;
    EQNED = t.eq; WMEMD = t.wm; M2REGD = t.m2; ALUOPD = t.op; RTD = t.rt; RDD = t.rd;
    STALLD = t.st; FLUSHE = t.fl;
  endtask

  // One edge: advance the bench's own pipeline model, then compare every stage.
  task automatic run_vec(input vec_t t, input string tag);
    drive(t);
    if (mw.v) retired++;
    cnt  = cnt + {31'd0, mw.v};
    cnt4 = cnt4 + {3'd0, mw.v};
    mw = mm;
    mm = me;
    me.v = t.ev; me.wr = t.ewr; me.wm = t.ewm; me.m2 = t.em2; me.wreg = t.ewreg;
    @(posedge CLK); #1;
    chk({tag, ".E"}, {VALIDE, WREGE, ALUIMME, BRANCHE, EQNEE, WMEME, M2REGE, ALUOPE, WRITEREGE},
        {t.ev, t.ewr, t.eai, t.ebr, t.eeq, t.ewm, t.em2, t.eop, t.ewreg});
    chk({tag, ".M"}, {VALIDM, WREGM, WMEMM, M2REGM, WRITEREGM}, {mm.v, mm.wr, mm.wm, mm.m2, mm.wreg});
    chk({tag, ".W"}, {VALIDW, WREGW, M2REGW, WRITEREGW}, {mw.v, mw.wr, mw.m2, mw.wreg});
    chk({tag, ".instret"}, INSTRET, cnt);
    chk({tag, ".instret4"}, INSTRET4, cnt4);
  endtask

  task automatic clear_model();
    me = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    mm = me;
    mw = me;
    cnt = '0;
    cnt4 = '0;
    retired = 0;
  endtask

  initial begin
    //                v  wr rrt ai br eq wm m2 op     rt     rd    st fl   ev ewr eai ebr eeq ewm em2 eop   ewreg
    tbl[0]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b10, 5'd9, 5'd5, 0, 0,  1, 1, 0, 0, 0, 0, 0, 2'b10, 5'd5);
    tbl[1]  = mk(1, 1, 0, 1, 0, 0, 0, 1, 2'b00, 5'd7, 5'd0, 0, 0,  1, 1, 1, 0, 0, 0, 1, 2'b00, 5'd7);
    tbl[2]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 5'd3, 5'd0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);
    tbl[3]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 5'd3, 5'd0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);
    tbl[4]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 5'd3, 5'd0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 2'b00, 5'd3);
    tbl[5]  = mk(1, 0, 0, 1, 0, 0, 1, 0, 2'b00, 5'd4, 5'd0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);
    tbl[6]  = mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b10, 5'd1, 5'd2, 1, 1,  0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 1, 0, 2'b01, 5'd6, 5'd0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);
    tbl[8]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 2'b01, 5'd2, 5'd0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 2'b01, 5'd2);
    tbl[9]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 2'b01, 5'd3, 5'd0, 0, 0,  1, 0, 0, 1, 1, 0, 0, 2'b01, 5'd3);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);
    tbl[11] = mk(1, 0, 0, 1, 0, 0, 1, 0, 2'b00, 5'd8, 5'd0, 0, 0,  1, 0, 1, 0, 0, 1, 0, 2'b00, 5'd8);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2'b00, 5'd0);

    clear_model();
    RST = 1'b1;
    drive(tbl[0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("reset_hold.outs", {33'd0, all_out}, 64'd0);
      chk("reset_hold.instret", INSTRET, 32'd0);
    end
    RST = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    chk("seq.instret_total", INSTRET, 32'd6);

    // Three valid entries in flight, then an asynchronous reset mid-cycle.
    vv = tbl[0];
    for (int i = 0; i < 3; i++) run_vec(vv, $sformatf("pre_rst%0d", i));
    chk("pre_rst.instret", INSTRET, 32'd7);
    #2 RST = 1'b1;
    #1;
    chk("async_rst.outs", {33'd0, all_out}, 64'd0);
    chk("async_rst.instret", INSTRET, 32'd0);
    @(posedge CLK); #1;
    chk("async_rst.edge_outs", {33'd0, all_out}, 64'd0);
    chk("async_rst.edge_instret", INSTRET, 32'd0);
    RST = 1'b0;
    clear_model();

    // 17 retirements on the 4-bit counter instance.
    for (int i = 0; i < 20; i++) begin
      run_vec(i < 17 ? tbl[1] : tbl[12], $sformatf("wrap%0d", i));
      if (i == 17) chk("wrap.after15", INSTRET4, 4'd15);
      if (i == 18) chk("wrap.after16", INSTRET4, 4'd0);
      if (i == 19) chk("wrap.after17", INSTRET4, 4'd1);
    end
    chk("wrap.retired", retired, 17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
